// File: rtl/musk_fetch_pkg.sv
// Shared definitions for the instruction-fetch line buffer.
//   LINE_BYTES / LINE_BITS : geometry of one cache line
//   fetch_state_t          : fetch request state machine encoding
//   line_base()            : align a byte address down to its line
package musk_fetch_pkg;

    localparam int LINE_BYTES = 64;
    localparam int LINE_BITS  = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [63:0] line_base(input logic [63:0] addr);
        return {addr[63:6], 6'b000000};
    endfunction

endpackage

// File: rtl/fetch_byte_ring.sv
// Circular byte store for the fetch queue.
//   clk      : clock
//   wr_en    : write one cache line this cycle
//   wr_ptr   : queue slot receiving the first kept byte (tail)
//   wr_skip  : leading line bytes to drop (entry offset of the first line)
//   wr_line  : 64 B line, byte k = wr_line[8k +: 8]
//   rd_ptr   : queue slot of window byte 0 (head)
//   rd_count : number of valid window bytes; lanes at or above it read as zero
//   rd_win   : decoder window, byte j = rd_win[8j +: 8]
module fetch_byte_ring
    import musk_fetch_pkg::*;
#(
    parameter int BUF_BYTES = 128,
    parameter int WIN_BYTES = 16
) (
    input  logic                              clk,
    input  logic                              wr_en,
    input  logic [$clog2(BUF_BYTES)-1:0]      wr_ptr,
    input  logic [5:0]                        wr_skip,
    input  logic [0:LINE_BITS-1]              wr_line,
    input  logic [$clog2(BUF_BYTES)-1:0]      rd_ptr,
    input  logic [$clog2(WIN_BYTES):0]        rd_count,
    output logic [0:8*WIN_BYTES-1]            rd_win
);

    localparam int PTR_W = $clog2(BUF_BYTES);

    logic [7:0] mem_q [BUF_BYTES];

    // Line write: kept byte k lands at tail + (k - skip); pointer math wraps naturally at PTR_W bits.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
                if (k >= int'(wr_skip)) begin
                    mem_q[wr_ptr + PTR_W'(k) - PTR_W'(wr_skip)] <= wr_line[8*k +: 8];
                end
            end
        end
    end

    // Window read from head with wrap; invalid lanes forced to zero so an empty queue shows a clean window.
    always_comb begin
        rd_win = '0;
        for (int j = 0; j < WIN_BYTES; j++) begin
            if (j < int'(rd_count)) begin
                rd_win[8*j +: 8] = mem_q[rd_ptr + PTR_W'(j)];
            end else begin
                rd_win[8*j +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/fetch_line_buffer.sv
// Instruction-fetch front end between the read cache and the decoder.
//   clk, reset              : clock, synchronous active-high reset
//   entry                   : start PC, loaded while reset is high
//   cache_reqcyc/cache_addr : registered line request, held until cache_respcyc
//   cache_respcyc/cache_data: one-cycle line return
//   redirect/redirect_pc    : flush queue and restart fetch at a new PC
//   win_bytes/win_count/win_pc : decoder window at the queue head
//   consume                 : bytes taken by the decoder (clamped to win_count)
module fetch_line_buffer
    import musk_fetch_pkg::*;
#(
    parameter int BUF_BYTES = 128,
    parameter int WIN_BYTES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [63:0]                    entry,
    output logic                           cache_reqcyc,
    output logic [63:0]                    cache_addr,
    input  logic                           cache_respcyc,
    input  logic [0:LINE_BITS-1]           cache_data,
    input  logic                           redirect,
    input  logic [63:0]                    redirect_pc,
    output logic [0:8*WIN_BYTES-1]         win_bytes,
    output logic [$clog2(WIN_BYTES):0]     win_count,
    output logic [63:0]                    win_pc,
    input  logic [$clog2(WIN_BYTES):0]     consume
);

    localparam int PTR_W = $clog2(BUF_BYTES);
    localparam int CNT_W = PTR_W + 1;
    localparam int WC_W  = $clog2(WIN_BYTES) + 1;

    fetch_state_t      state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [63:0]       win_pc_q, win_pc_d;
    logic [63:0]       fetch_addr_q, fetch_addr_d;
    logic              first_line_q, first_line_d;
    logic              reqcyc_q, reqcyc_d;
    logic [63:0]       addr_q, addr_d;

    logic [WC_W-1:0]   win_cnt_s;
    logic [WC_W-1:0]   take_s;
    logic [5:0]        skip_s;
    logic [6:0]        fill_len_s;
    logic              fill_s;

    // Window occupancy and decoder-side clamp.
    always_comb begin
        if (count_q >= CNT_W'(WIN_BYTES)) begin
            win_cnt_s = WC_W'(WIN_BYTES);
        end else begin
            win_cnt_s = count_q[WC_W-1:0];
        end
        if (consume > win_cnt_s) begin
            take_s = win_cnt_s;
        end else begin
            take_s = consume;
        end
    end

    // Fill qualification: only the first line after entry/redirect drops its leading bytes.
    always_comb begin
        if (first_line_q) begin
            skip_s = fetch_addr_q[5:0];
        end else begin
            skip_s = 6'd0;
        end
        fill_len_s = 7'd64 - {1'b0, skip_s};
        fill_s     = (state_q == REQ) && cache_respcyc && !redirect;
    end

    // Queue pointers, count and PCs; a redirect overrides any fill or consume in the same cycle.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        win_pc_d     = win_pc_q;
        fetch_addr_d = fetch_addr_q;
        first_line_d = first_line_q;
        if (redirect) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            win_pc_d     = redirect_pc;
            fetch_addr_d = redirect_pc;
            first_line_d = 1'b1;
        end else begin
            head_d   = head_q + PTR_W'(take_s);
            win_pc_d = win_pc_q + 64'(take_s);
            if (fill_s) begin
                tail_d       = tail_q + PTR_W'(fill_len_s);
                count_d      = count_q + CNT_W'(fill_len_s) - CNT_W'(take_s);
                fetch_addr_d = line_base(fetch_addr_q) + 64'd64;
                first_line_d = 1'b0;
            end else begin
                count_d = count_q - CNT_W'(take_s);
            end
        end
    end

    // Request FSM; the request flop mirrors "a line is outstanding" so it stays up through DRAIN.
    always_comb begin
        state_d  = state_q;
        reqcyc_d = reqcyc_q;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (!redirect && (count_q <= CNT_W'(BUF_BYTES - LINE_BYTES))) begin
                    state_d  = REQ;
                    reqcyc_d = 1'b1;
                    addr_d   = line_base(fetch_addr_q);
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (cache_respcyc) begin
                    state_d  = IDLE;
                    reqcyc_d = 1'b0;
                end else if (redirect) begin
                    state_d = DRAIN;
                end else begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (cache_respcyc) begin
                    state_d  = IDLE;
                    reqcyc_d = 1'b0;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d  = IDLE;
                reqcyc_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; entry seeds both PCs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            win_pc_q     <= entry;
            fetch_addr_q <= entry;
            first_line_q <= 1'b1;
            reqcyc_q     <= 1'b0;
            addr_q       <= 64'd0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            win_pc_q     <= win_pc_d;
            fetch_addr_q <= fetch_addr_d;
            first_line_q <= first_line_d;
            reqcyc_q     <= reqcyc_d;
            addr_q       <= addr_d;
        end
    end

    fetch_byte_ring #(
        .BUF_BYTES (BUF_BYTES),
        .WIN_BYTES (WIN_BYTES)
    ) u_ring (
        .clk      (clk),
        .wr_en    (fill_s),
        .wr_ptr   (tail_q),
        .wr_skip  (skip_s),
        .wr_line  (cache_data),
        .rd_ptr   (head_q),
        .rd_count (win_cnt_s),
        .rd_win   (win_bytes)
    );

    assign cache_reqcyc = reqcyc_q;
    assign cache_addr   = addr_q;
    assign win_count    = win_cnt_s;
    assign win_pc       = win_pc_q;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Randomized bench for fetch_line_buffer with a byte-queue reference model.
// The cache model answers each request with bytes equal to their own address[7:0].
module tb_fetch_line_buffer;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   entry;
    logic          cache_reqcyc;
    logic [63:0]   cache_addr;
    logic          cache_respcyc;
    logic [0:511]  cache_data;
    logic          redirect;
    logic [63:0]   redirect_pc;
    logic [0:127]  win_bytes;
    logic [4:0]    win_count;
    logic [63:0]   win_pc;
    logic [4:0]    consume;

    always #5 clk = ~clk;

    fetch_line_buffer #(.BUF_BYTES(128), .WIN_BYTES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .entry         (entry),
        .cache_reqcyc  (cache_reqcyc),
        .cache_addr    (cache_addr),
        .cache_respcyc (cache_respcyc),
        .cache_data    (cache_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .win_bytes     (win_bytes),
        .win_count     (win_count),
        .win_pc        (win_pc),
        .consume       (consume)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0]  mq[$];
    logic [63:0] mpc;
    logic [63:0] mfetch;
    bit          mfirst;
    // cache model state
    bit          pend;
    bit          discard;
    int          lat;
    int          cache_lat;
    bit          rand_lat;
    logic [63:0] req_addr;
    int          n_reqs;
    int          last_pre_cnt;
    bit          last_redir;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [63:0] e);
        @(negedge clk);
        reset = 1'b1; entry = e; consume = 5'd0; redirect = 1'b0;
        redirect_pc = 64'd0; cache_respcyc = 1'b0; cache_data = '0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_reqcyc", {63'd0, cache_reqcyc}, 64'd0);
        check_val("rst_addr", cache_addr, 64'd0);
        check_val("rst_wcount", {59'd0, win_count}, 64'd0);
        check_val("rst_wbytes_hi", win_bytes[0:63], 64'd0);
        check_val("rst_wbytes_lo", win_bytes[64:127], 64'd0);
        check_val("rst_wpc", win_pc, e);
        reset = 1'b0;
        mq.delete(); mpc = e; mfetch = e; mfirst = 1'b1;
        pend = 1'b0; discard = 1'b0; lat = 0; n_reqs = 0;
        last_pre_cnt = 0; last_redir = 1'b0;
    endtask

    // One clock: compare at negedge, run the cache model, drive inputs, advance the model.
    task automatic cycle(input logic [4:0] cons, input logic redir, input logic [63:0] rpc);
        int  n;
        int  wc;
        int  c;
        int  skip;
        bit  resp;
        n  = mq.size();
        wc = (n < 16) ? n : 16;
        check_val("win_count", {59'd0, win_count}, 64'(wc));
        check_val("win_pc", win_pc, mpc);
        for (int j = 0; j < wc; j++) begin
            check_val("win_byte", {56'd0, win_bytes[8*j +: 8]}, {56'd0, mq[j]});
        end
        resp = 1'b0;
        if (pend) begin
            check_val("req_held", {63'd0, cache_reqcyc}, 64'd1);
            check_val("addr_held", cache_addr, req_addr);
            if (lat == 0) begin
                resp = 1'b1;
                pend = 1'b0;
            end else begin
                lat--;
            end
        end else if (cache_reqcyc) begin
            check_val("req_addr", cache_addr, {mfetch[63:6], 6'd0});
            check_val("req_room", 64'(last_pre_cnt <= 64), 64'd1);
            check_val("req_after_redir", {63'd0, last_redir}, 64'd0);
            pend = 1'b1; discard = 1'b0;
            req_addr = {mfetch[63:6], 6'd0};
            lat = rand_lat ? $urandom_range(0, 3) : cache_lat;
            n_reqs++;
        end
        consume = cons; redirect = redir; redirect_pc = rpc; cache_respcyc = resp;
        for (int k = 0; k < 64; k++) cache_data[8*k +: 8] = 8'(req_addr + 64'(k));
        last_pre_cnt = n; last_redir = redir;
        if (redir) begin
            if (pend) discard = 1'b1;
            mq.delete(); mpc = rpc; mfetch = rpc; mfirst = 1'b1;
        end else begin
            c = (int'(cons) > wc) ? wc : int'(cons);
            for (int i = 0; i < c; i++) void'(mq.pop_front());
            mpc = mpc + 64'(c);
            if (resp && !discard) begin
                skip = mfirst ? int'(mfetch[5:0]) : 0;
                for (int k = skip; k < 64; k++) mq.push_back(8'(req_addr + 64'(k)));
                mfetch = req_addr + 64'd64;
                mfirst = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_reqs(input int target, input int bound, input string tag);
        int i;
        i = 0;
        while (n_reqs < target && i < bound) begin
            cycle(5'd0, 1'b0, 64'd0);
            i++;
        end
        if (n_reqs < target) check_val(tag, 64'(n_reqs), 64'(target));
    endtask

    initial begin
        reset = 1'b1; entry = 64'd0; consume = 5'd0; redirect = 1'b0;
        redirect_pc = 64'd0; cache_respcyc = 1'b0; cache_data = '0;
        cache_lat = 2; rand_lat = 1'b0; req_addr = 64'd0;

        // 1: aligned entry, first line and next request
        do_reset(64'h1000);
        run_until_reqs(1, 10, "t1_req_timeout");
        check_val("t1_addr0", cache_addr, 64'h1000);
        repeat (3) cycle(5'd0, 1'b0, 64'd0);
        check_val("t1_wcount", {59'd0, win_count}, 64'd16);
        check_val("t1_byte0", {56'd0, win_bytes[0:7]}, 64'h00);
        check_val("t1_wpc", win_pc, 64'h1000);
        run_until_reqs(2, 10, "t1_req2_timeout");
        check_val("t1_addr1", cache_addr, 64'h1040);

        // 2: unaligned entry skips leading bytes
        do_reset(64'h1013);
        run_until_reqs(1, 10, "t2_req_timeout");
        repeat (3) cycle(5'd0, 1'b0, 64'd0);
        check_val("t2_count", 64'(mq.size()), 64'd45);
        check_val("t2_byte0", {56'd0, win_bytes[0:7]}, 64'h13);
        check_val("t2_wpc", win_pc, 64'h1013);
        run_until_reqs(2, 10, "t2_req2_timeout");
        check_val("t2_addr1", cache_addr, 64'h1040);

        // 3: queue fills and stops requesting, consuming frees room
        do_reset(64'h1000);
        repeat (40) cycle(5'd0, 1'b0, 64'd0);
        check_val("t3_reqs", 64'(n_reqs), 64'd2);
        check_val("t3_count", 64'(mq.size()), 64'd128);
        check_val("t3_reqcyc", {63'd0, cache_reqcyc}, 64'd0);
        repeat (4) cycle(5'd16, 1'b0, 64'd0);
        run_until_reqs(3, 10, "t3_req3_timeout");
        check_val("t3_addr2", cache_addr, 64'h1080);

        // 4: steady consume of 5 bytes wraps the ring
        do_reset(64'h1000);
        repeat (80) cycle(5'd5, 1'b0, 64'd0);

        // 5: over-consume is clamped
        do_reset(64'h103D);
        begin
            int i;
            i = 0;
            while (mq.size() != 3 && i < 20) begin
                cycle(5'd0, 1'b0, 64'd0);
                i++;
            end
            check_val("t5_count3", 64'(mq.size()), 64'd3);
        end
        cycle(5'd16, 1'b0, 64'd0);
        check_val("t5_wcount", {59'd0, win_count}, 64'd0);
        check_val("t5_wpc", win_pc, 64'h1040);

        // 6a: redirect with a request outstanding drains it
        do_reset(64'h1000);
        run_until_reqs(2, 30, "t6_req_timeout");
        cycle(5'd0, 1'b1, 64'h2008);
        run_until_reqs(3, 20, "t6_req3_timeout");
        check_val("t6_addr", cache_addr, 64'h2000);
        repeat (3) cycle(5'd0, 1'b0, 64'd0);
        check_val("t6_byte0", {56'd0, win_bytes[0:7]}, 64'h08);
        check_val("t6_wpc", win_pc, 64'h2008);

        // 6b: redirect coincident with the response drops the line without draining
        do_reset(64'h1000);
        run_until_reqs(2, 30, "t6b_req_timeout");
        cycle(5'd0, 1'b0, 64'd0);
        cycle(5'd0, 1'b0, 64'd0);
        cycle(5'd0, 1'b1, 64'h2008);
        run_until_reqs(3, 3, "t6b_req3_timeout");
        check_val("t6b_addr", cache_addr, 64'h2000);

        // randomized traffic
        rand_lat = 1'b1;
        do_reset({$urandom, $urandom});
        for (int t = 0; t < 3000; t++) begin
            logic [4:0]  cons;
            logic        redir;
            logic [63:0] rpc;
            cons  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            redir = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) begin
                rpc = 64'hFFFF_FFFF_FFFF_FF80 + 64'($urandom_range(0, 127));
            end else begin
                rpc = {$urandom, $urandom};
            end
            if ($urandom_range(0, 999) == 0) begin
                do_reset({$urandom, $urandom});
            end else begin
                cycle(cons, redir, rpc);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
